press_sequencer: RTL and testbench



---
 rtl/press_sequencer.sv | 139 +++++++++++++
 tb/tb_press_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/press_sequencer.sv
// Push-button sequencer: short press increments, double press decrements, long press clears.
// Define BTN_SYNC_EN to pass btn through a 2-flop synchronizer (adds 2 cycles of latency).
module press_sequencer #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int LONG_MS = 1000,
  parameter int DBL_MS  = 300,
  parameter int WIDTH   = 4
) (
  input  logic             real_clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             evt_inc,
  output logic             evt_dec,
  output logic             evt_clr,
  output logic             busy
);

  localparam int LONG_T = CLK_HZ / 1000 * LONG_MS;
  localparam int DBL_T  = CLK_HZ / 1000 * DBL_MS;
  localparam int MAX_T  = (LONG_T > DBL_T) ? LONG_T : DBL_T;
  localparam int TW     = $clog2(MAX_T) + 1;
  localparam logic [TW-1:0] LONG_END = TW'(LONG_T - 1);
  localparam logic [TW-1:0] DBL_END  = TW'(DBL_T - 1);

  typedef enum logic [1:0] {IDLE, PRESS1, WAIT2, REL_WAIT} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          btn_q;
  logic          btn_s;
  logic          rise;

  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] c);
    return c + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] wrap_dec(input logic [WIDTH-1:0] c);
    return c - WIDTH'(1);
  endfunction

`ifdef BTN_SYNC_EN
  logic btn_p0;
  logic btn_p1;

  // Synchronizer stage boundary: resets to "pressed" so a held button never looks like an edge
  always_ff @(posedge real_clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0 <= 1'b1;
      btn_p1 <= 1'b1;
    end else begin
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
    end
  end

  assign btn_s = btn_p1;
`else
  assign btn_s = btn;
`endif

  assign rise = btn_s & ~btn_q;

  // Classifier stage boundary: events and count updates register on the same edge
  always_ff @(posedge real_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      btn_q   <= 1'b1;
      count   <= '0;
      evt_inc <= 1'b0;
      evt_dec <= 1'b0;
      evt_clr <= 1'b0;
      busy    <= 1'b0;
    end else begin
      btn_q   <= btn_s;
      evt_inc <= 1'b0;
      evt_dec <= 1'b0;
      evt_clr <= 1'b0;
      if (!en) begin
        state <= IDLE;
        timer <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= PRESS1;
              timer <= '0;
              busy  <= 1'b1;
            end
          end
          PRESS1: begin
            if (!btn_s) begin
              state <= WAIT2;
              timer <= '0;
            end else if (timer == LONG_END) begin
              evt_clr <= 1'b1;
              count   <= '0;
              state   <= REL_WAIT;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          WAIT2: begin
            // A second press beats the window expiring in the same cycle
            if (rise) begin
              evt_dec <= 1'b1;
              count   <= wrap_dec(count);
              state   <= REL_WAIT;
            end else if (timer == DBL_END) begin
              evt_inc <= 1'b1;
              count   <= wrap_inc(count);
              state   <= IDLE;
              timer   <= '0;
              busy    <= 1'b0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          REL_WAIT: begin
            if (!btn_s) begin
              state <= IDLE;
              timer <= '0;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_press_sequencer.sv
// Bench for press_sequencer: directed scenarios plus random press trains checked against a waveform-scanning model.
module tb_press_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int LONG_MS = 10;
  localparam int DBL_MS  = 5;
  localparam int WIDTH   = 4;
  localparam int LONG_T  = CLK_HZ / 1000 * LONG_MS;
  localparam int DBL_T   = CLK_HZ / 1000 * DBL_MS;
  localparam int MOD     = 1 << WIDTH;

  logic             real_clk = 1'b0;
  logic             rst_n    = 1'b1;
  logic             btn      = 1'b0;
  logic             en       = 1'b1;
  logic [WIDTH-1:0] count;
  logic             evt_inc;
  logic             evt_dec;
  logic             evt_clr;
  logic             busy;

  press_sequencer #(
    .CLK_HZ(CLK_HZ), .LONG_MS(LONG_MS), .DBL_MS(DBL_MS), .WIDTH(WIDTH)
  ) dut (
    .real_clk(real_clk), .rst_n(rst_n), .btn(btn), .en(en), .count(count),
    .evt_inc(evt_inc), .evt_dec(evt_dec), .evt_clr(evt_clr), .busy(busy)
  );

  always #5 real_clk = ~real_clk;

  int vectors     = 0;
  int miscompares = 0;

  bit stim[$];
  bit stim_en[$];
  bit o_inc[$];
  bit o_dec[$];
  bit o_clr[$];
  bit o_busy[$];
  int o_cnt[$];
  int n_inc, n_dec, n_clr;
  bit last_btn;
  int mdl_count;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  task automatic clear_stim();
    stim.delete();
    stim_en.delete();
  endtask

  task automatic push_en(input bit b, input bit e, input int n);
    repeat (n) begin
      stim.push_back(b);
      stim_en.push_back(e);
    end
  endtask

  task automatic push(input bit b, input int n);
    push_en(b, 1'b1, n);
  endtask

  task automatic add_press(input int hold, input int gap);
    push(1'b1, hold);
    push(1'b0, gap);
  endtask

  task automatic drive();
    o_inc.delete(); o_dec.delete(); o_clr.delete(); o_busy.delete(); o_cnt.delete();
    n_inc = 0; n_dec = 0; n_clr = 0;
    foreach (stim[i]) begin
      @(negedge real_clk);
      btn = stim[i];
      en  = stim_en[i];
      @(posedge real_clk);
      #1;
      o_inc.push_back(evt_inc);
      o_dec.push_back(evt_dec);
      o_clr.push_back(evt_clr);
      o_busy.push_back(busy);
      o_cnt.push_back(int'(count));
      n_inc += int'(evt_inc);
      n_dec += int'(evt_dec);
      n_clr += int'(evt_clr);
    end
    last_btn = stim[stim.size() - 1];
    en = 1'b1;
  endtask

  function automatic bit rise_at(int i, bit prev0);
    bit p;
    p = (i == 0) ? prev0 : stim[i-1];
    return stim[i] && !p;
  endfunction

  function automatic int next_rise(int from, bit prev0);
    for (int i = from; i < stim.size(); i++)
      if (rise_at(i, prev0)) return i;
    return stim.size();
  endfunction

  function automatic int first_low(int from);
    for (int i = from; i < stim.size(); i++)
      if (!stim[i]) return i;
    return stim.size();
  endfunction

  // Reference: classify each press from the btn waveform and place its event at the specified latency
  task automatic check_model(input string name, input bit prev0);
    int n, i, r, z, r2, cnt;
    int ev[$];
    bit [2:0] got, want;
    n = stim.size();
    for (int k = 0; k < n; k++) ev.push_back(0);
    i = 0;
    while (i < n) begin
      r = next_rise(i, prev0);
      if (r >= n) break;
      z = first_low(r + 1);
      if (z - r > LONG_T) begin
        ev[r + LONG_T] = 3;
        i = z + 1;
      end else begin
        if (z >= n) break;
        r2 = next_rise(z + 1, prev0);
        if (r2 < n && r2 <= z + DBL_T) begin
          ev[r2] = 2;
          i = first_low(r2 + 1) + 1;
        end else if (z + DBL_T < n) begin
          ev[z + DBL_T] = 1;
          i = z + DBL_T + 1;
        end else begin
          break;
        end
      end
    end
    cnt = mdl_count;
    for (int k = 0; k < n; k++) begin
      case (ev[k])
        1: cnt = (cnt + 1) % MOD;
        2: cnt = (cnt + MOD - 1) % MOD;
        3: cnt = 0;
        default: ;
      endcase
      got  = {o_inc[k], o_dec[k], o_clr[k]};
      want = {ev[k] == 1, ev[k] == 2, ev[k] == 3};
      vectors++;
      if (got !== want || o_cnt[k] != cnt) begin
        miscompares++;
        $display("FAIL %s cycle %0d: evt(inc,dec,clr)=%b count=%0d, expected evt=%b count=%0d",
                 name, k, got, o_cnt[k], want, cnt);
      end
    end
    mdl_count = cnt;
  endtask

  task automatic run_checked(input string name);
    bit prev;
    prev = last_btn;
    drive();
    check_model(name, prev);
  endtask

  task automatic do_reset(input bit b);
    @(negedge real_clk);
    btn = b;
    en = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge real_clk);
    @(negedge real_clk);
    rst_n = 1'b1;
    last_btn = 1'b1;
    mdl_count = 0;
  endtask

  task automatic test_reset();
    btn = 1'b0; en = 1'b1; rst_n = 1'b1;
    repeat (3) @(posedge real_clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (count !== '0) begin
      miscompares++; $display("FAIL reset_count: got %0d, expected 0", count);
    end
    vectors++;
    if ({evt_inc, evt_dec, evt_clr} !== 3'b000) begin
      miscompares++; $display("FAIL reset_evt: got %b, expected 000", {evt_inc, evt_dec, evt_clr});
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    @(negedge real_clk);
    rst_n = 1'b1;
    last_btn = 1'b1;
    mdl_count = 0;
  endtask

  task automatic test_short();
    clear_stim();
    push(1'b0, 1); push(1'b1, 3); push(1'b0, 10);
    run_checked("short");
    vectors++;
    if (o_inc[9] !== 1'b1 || n_inc != 1) begin
      miscompares++; $display("FAIL short_inc: pulse@9=%b total=%0d, expected 1 and 1", o_inc[9], n_inc);
    end
    vectors++;
    if (o_busy[5] !== 1'b1 || o_busy[13] !== 1'b0) begin
      miscompares++; $display("FAIL short_busy: mid=%b end=%b, expected 1 and 0", o_busy[5], o_busy[13]);
    end
    vectors++;
    if (o_cnt[13] != 1) begin
      miscompares++; $display("FAIL short_count: got %0d, expected 1", o_cnt[13]);
    end
  endtask

  task automatic test_double();
    do_reset(1'b0);
    clear_stim();
    push(1'b0, 1); push(1'b1, 2); push(1'b0, 2); push(1'b1, 2); push(1'b0, 8);
    run_checked("double");
    vectors++;
    if (o_dec[5] !== 1'b1 || n_dec != 1 || n_inc != 0) begin
      miscompares++;
      $display("FAIL double_dec: dec@5=%b decs=%0d incs=%0d, expected 1,1,0", o_dec[5], n_dec, n_inc);
    end
    vectors++;
    if (o_cnt[5] != 15 || o_cnt[o_cnt.size() - 1] != 15) begin
      miscompares++;
      $display("FAIL double_count: at dec=%0d final=%0d, expected 15 and 15", o_cnt[5], o_cnt[o_cnt.size() - 1]);
    end
  endtask

  task automatic test_long();
    do_reset(1'b0);
    clear_stim();
    push(1'b0, 1);
    repeat (7) add_press(2, 6);
    run_checked("long_setup");
    vectors++;
    if (o_cnt[o_cnt.size() - 1] != 7) begin
      miscompares++; $display("FAIL long_setup_count: got %0d, expected 7", o_cnt[o_cnt.size() - 1]);
    end
    clear_stim();
    push(1'b1, 20); push(1'b0, 8);
    run_checked("long");
    vectors++;
    if (o_clr[10] !== 1'b1 || o_cnt[9] != 7 || o_cnt[10] != 0) begin
      miscompares++;
      $display("FAIL long_clr: clr@10=%b count@9=%0d count@10=%0d, expected 1,7,0", o_clr[10], o_cnt[9], o_cnt[10]);
    end
    vectors++;
    if (n_inc + n_dec + n_clr != 1) begin
      miscompares++; $display("FAIL long_events: got %0d events, expected 1", n_inc + n_dec + n_clr);
    end
  endtask

  task automatic test_wrap16();
    int adj;
    do_reset(1'b0);
    clear_stim();
    push(1'b0, 1);
    repeat (16) add_press(1 + int'($urandom_range(0, 2)), 6 + int'($urandom_range(0, 3)));
    run_checked("wrap16");
    adj = 0;
    for (int k = 1; k < o_inc.size(); k++)
      if (o_inc[k] && o_inc[k-1]) adj++;
    vectors++;
    if (n_inc != 16 || adj != 0) begin
      miscompares++; $display("FAIL wrap16_pulses: got %0d pulses (%0d wide), expected 16 (0)", n_inc, adj);
    end
    vectors++;
    if (o_cnt[o_cnt.size() - 1] != 0) begin
      miscompares++; $display("FAIL wrap16_count: got %0d, expected 0", o_cnt[o_cnt.size() - 1]);
    end
  endtask

  task automatic test_held_reset_and_en();
    do_reset(1'b1);
    clear_stim();
    push(1'b1, 15); push(1'b0, 8);
    run_checked("held_reset");
    vectors++;
    if (n_inc + n_dec + n_clr != 0 || o_cnt[o_cnt.size() - 1] != 0) begin
      miscompares++;
      $display("FAIL held_reset: events=%0d count=%0d, expected 0 and 0", n_inc + n_dec + n_clr, o_cnt[o_cnt.size() - 1]);
    end
    clear_stim();
    push(1'b1, 2); push(1'b0, 6);
    run_checked("en_setup");
    // en dropped in PRESS1, then reasserted while still held
    clear_stim();
    push(1'b1, 3); push_en(1'b1, 1'b0, 2); push(1'b1, 12); push(1'b0, 8);
    drive();
    vectors++;
    if (o_busy[2] !== 1'b1 || o_busy[3] !== 1'b0 || o_busy[10] !== 1'b0) begin
      miscompares++;
      $display("FAIL en_press1_busy: busy@2=%b @3=%b @10=%b, expected 1,0,0", o_busy[2], o_busy[3], o_busy[10]);
    end
    vectors++;
    if (n_inc + n_dec + n_clr != 0 || o_cnt[o_cnt.size() - 1] != 1) begin
      miscompares++;
      $display("FAIL en_press1_discard: events=%0d count=%0d, expected 0 and 1", n_inc + n_dec + n_clr, o_cnt[o_cnt.size() - 1]);
    end
    // en dropped in WAIT2 discards the pending short press
    clear_stim();
    push(1'b1, 2); push(1'b0, 2); push_en(1'b0, 1'b0, 1); push(1'b0, 10);
    drive();
    vectors++;
    if (n_inc + n_dec + n_clr != 0 || o_cnt[o_cnt.size() - 1] != 1) begin
      miscompares++;
      $display("FAIL en_wait2_discard: events=%0d count=%0d, expected 0 and 1", n_inc + n_dec + n_clr, o_cnt[o_cnt.size() - 1]);
    end
  endtask

  task automatic test_async_and_race();
    do_reset(1'b0);
    clear_stim();
    push(1'b0, 1);
    repeat (5) add_press(2, 6);
    run_checked("async_setup");
    clear_stim();
    push(1'b1, 2); push(1'b0, 2);
    drive();
    vectors++;
    if (o_busy[3] !== 1'b1 || o_cnt[3] != 5) begin
      miscompares++; $display("FAIL async_pre: busy=%b count=%0d, expected 1 and 5", o_busy[3], o_cnt[3]);
    end
    @(posedge real_clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (count !== '0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: count=%0d busy=%b, expected 0 and 0", count, busy);
    end
    @(negedge real_clk);
    rst_n = 1'b1;
    last_btn = 1'b1;
    mdl_count = 0;
    clear_stim();
    push(1'b0, 1); push(1'b1, 2); push(1'b0, 5); push(1'b1, 2); push(1'b0, 8);
    run_checked("race");
    vectors++;
    if (o_dec[8] !== 1'b1 || n_inc != 0 || o_cnt[8] != 15) begin
      miscompares++;
      $display("FAIL race_dec_wins: dec@8=%b incs=%0d count=%0d, expected 1,0,15", o_dec[8], n_inc, o_cnt[8]);
    end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int round = 0; round < 8; round++) begin
      clear_stim();
      push(1'b0, 1);
      repeat (8) add_press(int'($urandom_range(1, 14)), int'($urandom_range(1, 8)));
      push(1'b0, DBL_T + 2);
      run_checked("random");
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_double();
    test_long();
    test_wrap16();
    test_held_reset_and_en();
    test_async_and_race();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
